// File: rtl/key_event_pkg.sv
// Shared types and constants for the key event queue.
// Holds the packed event record, the direction-key ASCII codes and a helper
// that maps a code onto its bit in the {right,down,left,up} held mask.
package key_event_pkg;

  typedef struct packed {
    logic       brk;   // 1 = release, 0 = press
    logic       ext;   // E0-extended scan code
    logic [7:0] code;  // ASCII of the key
  } key_event_t;

  localparam logic [7:0] KEY_UP    = 8'h77;  // 'w'
  localparam logic [7:0] KEY_LEFT  = 8'h61;  // 'a'
  localparam logic [7:0] KEY_DOWN  = 8'h73;  // 's'
  localparam logic [7:0] KEY_RIGHT = 8'h64;  // 'd'

  // One-hot position in the {right,down,left,up} mask, zero for other keys.
  function automatic logic [3:0] dir_mask(input logic [7:0] code);
    case (code)
      KEY_UP:    dir_mask = 4'b0001;
      KEY_LEFT:  dir_mask = 4'b0010;
      KEY_DOWN:  dir_mask = 4'b0100;
      KEY_RIGHT: dir_mask = 4'b1000;
      default:   dir_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/key_event_queue_if.sv
// Event-drain handshake between the key event queue and its consumer.
// Ports: ev_valid/ev_code/ev_break/ev_ext driven by the queue (master),
//        ev_ready driven by the consumer (slave); transfer when valid && ready.
interface key_event_queue_if;

  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_break;
  logic       ev_ext;

  modport master (
    output ev_valid, ev_code, ev_break, ev_ext,
    input  ev_ready
  );

  modport slave (
    input  ev_valid, ev_code, ev_break, ev_ext,
    output ev_ready
  );

endinterface

// File: rtl/key_event_fifo.sv
// Purpose: first-word-fall-through synchronous FIFO of key_event_t.
// Latency: a push is visible on head_o right after its clock edge.
// Backpressure: push while full is ignored unless a pop frees the slot in the same cycle.
// Ports: clk/rst (sync, active high), push_i/push_dat_i, pop_i, head_o,
//        full_o, empty_o, count_o (0..DEPTH).
module key_event_fifo
  import key_event_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  key_event_t       push_dat_i,
  input  logic             pop_i,
  output key_event_t       head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  key_event_t             mem_q [DEPTH];
  key_event_t             last_q, last_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   do_push;
  logic                   do_pop;

  always_comb begin
    empty_o  = (cnt_q == '0);
    full_o   = (cnt_q == CNT_W'(DEPTH));
    do_pop   = pop_i && !empty_o;
    // A simultaneous pop frees the slot, so a full FIFO can still accept.
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    last_d   = do_pop  ? mem_q[rd_ptr_q] : last_q;
    cnt_d    = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + CNT_W'(1);
    if (!do_push && do_pop) cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  // When empty, keep presenting the most recently popped entry.
  assign head_o  = empty_o ? last_q : mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/key_event_queue.sv
// Purpose: turns keyboard decoder levels into make/break events queued for a consumer.
// Latency: an event detected at a clock edge is on ev_if from that edge (1 clk).
// Backpressure: ev_ready gates pops; a push into a full queue without a pop is dropped and sets overflow.
// Ports: clk/rst (sync, active high); kb_key_state/kb_key_ascii/kb_long_code from the decoder;
//        ev_if (master) event handshake; ev_count occupancy; overflow sticky drop flag;
//        held {right,down,left,up} mask, live only when KEY_HELD_MASK_EN is defined.
module key_event_queue
  import key_event_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              kb_key_state,
  input  logic [7:0]        kb_key_ascii,
  input  logic              kb_long_code,
  key_event_queue_if.master ev_if,
  output logic [CNT_W-1:0]  ev_count,
  output logic              overflow,
  output logic [3:0]        held
);

  logic       prev_state_q, prev_state_d;
  logic [7:0] prev_ascii_q, prev_ascii_d;
  logic       prev_ext_q, prev_ext_d;
  logic       overflow_q, overflow_d;
  logic       make_det;
  logic       brk_det;
  logic       push;
  logic       pop;
  key_event_t push_dat;
  key_event_t head;
  logic       fifo_full;
  logic       fifo_empty;

  always_comb begin
    // A new ASCII while still held is a fresh press; no implicit release is queued.
    make_det     = kb_key_state && (!prev_state_q || (kb_key_ascii != prev_ascii_q));
    brk_det      = !kb_key_state && prev_state_q;
    push         = make_det || brk_det;
    // A release reports the key that was held, not what the decoder shows now.
    push_dat     = brk_det ? '{brk: 1'b1, ext: prev_ext_q,   code: prev_ascii_q}
                           : '{brk: 1'b0, ext: kb_long_code, code: kb_key_ascii};
    pop          = !fifo_empty && ev_if.ev_ready;
    prev_state_d = kb_key_state;
    prev_ascii_d = kb_key_ascii;
    prev_ext_d   = kb_long_code;
    overflow_d   = overflow_q || (push && fifo_full && !pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_state_q <= 1'b0;
      prev_ascii_q <= '0;
      prev_ext_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      prev_state_q <= prev_state_d;
      prev_ascii_q <= prev_ascii_d;
      prev_ext_q   <= prev_ext_d;
      overflow_q   <= overflow_d;
    end
  end

  key_event_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (ev_count)
  );

  assign ev_if.ev_valid = !fifo_empty;
  assign ev_if.ev_code  = head.code;
  assign ev_if.ev_break = head.brk;
  assign ev_if.ev_ext   = head.ext;
  assign overflow       = overflow_q;

`ifdef KEY_HELD_MASK_EN
  logic [3:0] held_q, held_d;

  // Tracks detections directly, so a dropped FIFO entry still updates the mask.
  always_comb begin
    held_d = held_q;
    if (make_det) held_d = held_d | dir_mask(kb_key_ascii);
    if (brk_det)  held_d = held_d & ~dir_mask(prev_ascii_q);
  end

  always_ff @(posedge clk) begin
    if (rst) held_q <= 4'b0000;
    else     held_q <= held_d;
  end

  assign held = held_q;
`else
  assign held = 4'b0000;
`endif

endmodule

// File: tb/tb_key_event_queue.sv
module tb_key_event_queue;

  logic       clk;
  logic       rst;
  logic       kb_key_state;
  logic [7:0] kb_key_ascii;
  logic       kb_long_code;
  logic [3:0] ev_count;
  logic       overflow;
  logic [3:0] held;

  int vectors;
  int miscompares;

  key_event_queue_if ev_if ();

  key_event_queue #(.DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .kb_key_state (kb_key_state),
    .kb_key_ascii (kb_key_ascii),
    .kb_long_code (kb_long_code),
    .ev_if        (ev_if.master),
    .ev_count     (ev_count),
    .overflow     (overflow),
    .held         (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected held mask depends on the build option.
  function automatic logic [3:0] exp_held(input logic [3:0] v);
`ifdef KEY_HELD_MASK_EN
    return v;
`else
    return 4'b0000 & v;
`endif
  endfunction

  // Advance one clock; inputs set afterwards apply at the next edge, outputs read here are post-edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; kb_key_state = 1'b0; kb_key_ascii = 8'h00; kb_long_code = 1'b0;
    ev_if.ev_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({ev_if.ev_valid, ev_if.ev_break, ev_if.ev_ext, ev_if.ev_code} !== 11'h000) begin
      miscompares++;
      $display("FAIL reset_ev got v%b b%b e%b c%h want all zero", ev_if.ev_valid, ev_if.ev_break, ev_if.ev_ext, ev_if.ev_code);
    end
    vectors++;
    if ({ev_count, overflow, held} !== 9'h000) begin
      miscompares++;
      $display("FAIL reset_status got cnt%0d ovf%b held%b want 0", ev_count, overflow, held);
    end
  endtask

  task automatic test_tap();
    do_reset();
    kb_key_state = 1'b1; kb_key_ascii = 8'h77;
    step();
    vectors++;
    if ({ev_if.ev_valid, ev_count} !== {1'b1, 4'd1}) begin
      miscompares++;
      $display("FAIL tap_make_latency got v%b cnt%0d want v1 cnt1", ev_if.ev_valid, ev_count);
    end
    vectors++;
    if (held !== exp_held(4'b0001)) begin
      miscompares++;
      $display("FAIL tap_held got %b want %b", held, exp_held(4'b0001));
    end
    repeat (4) step();
    kb_key_state = 1'b0;
    step();
    step();
    vectors++;
    if (ev_count !== 4'd2) begin
      miscompares++;
      $display("FAIL tap_count got %0d want 2", ev_count);
    end
    vectors++;
    if ({ev_if.ev_break, ev_if.ev_ext, ev_if.ev_code} !== 10'h077) begin
      miscompares++;
      $display("FAIL tap_head0 got %h want 077", {ev_if.ev_break, ev_if.ev_ext, ev_if.ev_code});
    end
    ev_if.ev_ready = 1'b1;
    step();
    vectors++;
    if ({ev_if.ev_valid, ev_if.ev_break, ev_if.ev_ext, ev_if.ev_code, ev_count} !== {1'b1, 10'h277, 4'd1}) begin
      miscompares++;
      $display("FAIL tap_head1 got v%b %h cnt%0d want v1 277 cnt1", ev_if.ev_valid, {ev_if.ev_break, ev_if.ev_ext, ev_if.ev_code}, ev_count);
    end
    step();
    vectors++;
    if ({ev_if.ev_valid, ev_count, held} !== 9'h000) begin
      miscompares++;
      $display("FAIL tap_drained got v%b cnt%0d held%b want 0", ev_if.ev_valid, ev_count, held);
    end
    ev_if.ev_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [7:0] c;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      kb_key_state = 1'b1; kb_key_ascii = 8'h41 + 8'(i);
      step();
    end
    vectors++;
    if ({ev_count, overflow, ev_if.ev_code} !== {4'd8, 1'b1, 8'h41}) begin
      miscompares++;
      $display("FAIL ovf_state got cnt%0d ovf%b head%h want cnt8 ovf1 head41", ev_count, overflow, ev_if.ev_code);
    end
    ev_if.ev_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      c = 8'h41 + 8'(i);
      vectors++;
      if ({ev_if.ev_valid, ev_if.ev_break, ev_if.ev_code} !== {1'b1, 1'b0, c}) begin
        miscompares++;
        $display("FAIL ovf_drain%0d got v%b b%b c%h want v1 b0 c%h", i, ev_if.ev_valid, ev_if.ev_break, ev_if.ev_code, c);
      end
      step();
    end
    vectors++;
    if ({ev_if.ev_valid, ev_count, overflow} !== {1'b0, 4'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL ovf_empty got v%b cnt%0d ovf%b want v0 cnt0 ovf1", ev_if.ev_valid, ev_count, overflow);
    end
    ev_if.ev_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [7:0] c;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      kb_key_state = 1'b1; kb_key_ascii = 8'h50 + 8'(i);
      step();
    end
    kb_key_ascii = 8'h58; ev_if.ev_ready = 1'b1;
    step();
    vectors++;
    if ({ev_count, overflow, ev_if.ev_code} !== {4'd8, 1'b0, 8'h51}) begin
      miscompares++;
      $display("FAIL full_pp got cnt%0d ovf%b head%h want cnt8 ovf0 head51", ev_count, overflow, ev_if.ev_code);
    end
    for (int i = 0; i < 8; i++) begin
      c = 8'h51 + 8'(i);
      vectors++;
      if ({ev_if.ev_valid, ev_if.ev_code} !== {1'b1, c}) begin
        miscompares++;
        $display("FAIL full_drain%0d got v%b c%h want v1 c%h", i, ev_if.ev_valid, ev_if.ev_code, c);
      end
      step();
    end
    vectors++;
    if ({ev_if.ev_valid, overflow} !== 2'b00) begin
      miscompares++;
      $display("FAIL full_end got v%b ovf%b want v0 ovf0", ev_if.ev_valid, overflow);
    end
    ev_if.ev_ready = 1'b0;
  endtask

  task automatic test_switch();
    logic [9:0] exp_ev [3];
    exp_ev[0] = 10'h061; exp_ev[1] = 10'h064; exp_ev[2] = 10'h264;
    do_reset();
    kb_key_state = 1'b1; kb_key_ascii = 8'h61;
    step();
    vectors++;
    if (held !== exp_held(4'b0010)) begin
      miscompares++;
      $display("FAIL sw_held_a got %b want %b", held, exp_held(4'b0010));
    end
    kb_key_ascii = 8'h64;
    step();
    vectors++;
    if ({ev_count, held} !== {4'd2, exp_held(4'b1010)}) begin
      miscompares++;
      $display("FAIL sw_held_ad got cnt%0d held%b want cnt2 held%b", ev_count, held, exp_held(4'b1010));
    end
    kb_key_state = 1'b0;
    step();
    vectors++;
    if ({ev_count, held} !== {4'd3, exp_held(4'b0010)}) begin
      miscompares++;
      $display("FAIL sw_held_rel got cnt%0d held%b want cnt3 held%b", ev_count, held, exp_held(4'b0010));
    end
    ev_if.ev_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if ({ev_if.ev_valid, ev_if.ev_break, ev_if.ev_ext, ev_if.ev_code} !== {1'b1, exp_ev[i]}) begin
        miscompares++;
        $display("FAIL sw_ev%0d got %h want %h", i, {ev_if.ev_break, ev_if.ev_ext, ev_if.ev_code}, exp_ev[i]);
      end
      step();
    end
    ev_if.ev_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      kb_key_state = 1'b1; kb_key_ascii = 8'h41 + 8'(i);
      step();
    end
    vectors++;
    if (ev_count !== 4'd3) begin
      miscompares++;
      $display("FAIL rm_queued got %0d want 3", ev_count);
    end
    rst = 1'b1; kb_key_ascii = 8'h73; kb_long_code = 1'b1;
    step();
    vectors++;
    if ({ev_if.ev_valid, ev_count, overflow, held} !== 10'h000) begin
      miscompares++;
      $display("FAIL rm_cleared got v%b cnt%0d ovf%b held%b want 0", ev_if.ev_valid, ev_count, overflow, held);
    end
    rst = 1'b0;
    step();
    vectors++;
    if ({ev_if.ev_valid, ev_count, ev_if.ev_break, ev_if.ev_ext, ev_if.ev_code} !== {1'b1, 4'd1, 10'h173}) begin
      miscompares++;
      $display("FAIL rm_make got v%b cnt%0d %h want v1 cnt1 173", ev_if.ev_valid, ev_count, {ev_if.ev_break, ev_if.ev_ext, ev_if.ev_code});
    end
    vectors++;
    if (held !== exp_held(4'b0100)) begin
      miscompares++;
      $display("FAIL rm_held got %b want %b", held, exp_held(4'b0100));
    end
    // Release with long_code already dropped: break must carry the held key's ext.
    kb_key_state = 1'b0; kb_long_code = 1'b0;
    step();
    ev_if.ev_ready = 1'b1;
    step();
    vectors++;
    if ({ev_count, ev_if.ev_break, ev_if.ev_ext, ev_if.ev_code} !== {4'd1, 10'h373}) begin
      miscompares++;
      $display("FAIL rm_break got cnt%0d %h want cnt1 373", ev_count, {ev_if.ev_break, ev_if.ev_ext, ev_if.ev_code});
    end
    step();
    ev_if.ev_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] c;
    do_reset();
    ev_if.ev_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      c = 8'h20 + 8'(i);
      kb_key_state = 1'b1; kb_key_ascii = c;
      step();
      vectors++;
      if ({ev_if.ev_valid, ev_count, ev_if.ev_break, ev_if.ev_code} !== {1'b1, 4'd1, 1'b0, c}) begin
        miscompares++;
        $display("FAIL b2b%0d got v%b cnt%0d b%b c%h want v1 cnt1 b0 c%h", i, ev_if.ev_valid, ev_count, ev_if.ev_break, ev_if.ev_code, c);
      end
    end
    step();
    vectors++;
    if ({ev_if.ev_valid, ev_count} !== 5'h00) begin
      miscompares++;
      $display("FAIL b2b_end got v%b cnt%0d want v0 cnt0", ev_if.ev_valid, ev_count);
    end
    ev_if.ev_ready = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; kb_key_state = 1'b0; kb_key_ascii = 8'h00; kb_long_code = 1'b0;
    ev_if.ev_ready = 1'b0;
    test_reset();
    test_tap();
    test_overflow();
    test_full_push_pop();
    test_switch();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
